// File: rtl/trigout_arbiter_if.sv
// Trigger-output arbitration bus: channel-side requests and peripheral-side 4-phase handshake.
interface trigout_arbiter_if #(
  parameter int NUM_CH   = 4,
  parameter int NUM_TRIG = 2,
  parameter int SEL_W    = 6
);
  logic [NUM_CH-1:0]       ch_trigout_req;
  logic [NUM_CH*SEL_W-1:0] ch_trigout_sel;
  logic [NUM_CH-1:0]       ch_trigout_ack;
  logic [NUM_TRIG-1:0]     trig_out_req;
  logic [NUM_TRIG-1:0]     trig_out_ack;
  logic [NUM_CH-1:0]       trigout_selerr;
  logic                    err_clr;

  modport master (
    output ch_trigout_req, ch_trigout_sel, trig_out_ack, err_clr,
    input  ch_trigout_ack, trig_out_req, trigout_selerr
  );

  modport slave (
    input  ch_trigout_req, ch_trigout_sel, trig_out_ack, err_clr,
    output ch_trigout_ack, trig_out_req, trigout_selerr
  );
endinterface

// File: rtl/trigout_arbiter.sv
// Round-robin arbiter sharing peripheral trigger-output lines between DMA channels,
// one independent 4-phase handshake FSM per output line.
//
// state     | meaning
// S_IDLE    | line free, waiting for a valid request
// S_REQ     | trig_out_req high, waiting for peripheral ack
// S_ACK_LOW | channel acked, waiting for peripheral ack to drop
module trigout_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int NUM_TRIG = 2,
  parameter int SEL_W    = 6
) (
  input logic              clk,
  input logic              rst,
  trigout_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [SEL_W-1:0] TRIG_LIM = SEL_W'(NUM_TRIG);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK_LOW} state_e;

  state_e                          state_q [NUM_TRIG];
  state_e                          state_d [NUM_TRIG];
  logic [NUM_TRIG-1:0][CH_W-1:0]   g_q, g_d;
  logic [NUM_TRIG-1:0][CH_W-1:0]   p_q, p_d;
  logic [NUM_TRIG-1:0]             trig_req_q, trig_req_d;
  logic [NUM_CH-1:0]               ch_ack_q, ch_ack_d;
  logic [NUM_CH-1:0]               selerr_q, selerr_d;

  logic [SEL_W-1:0]  sel    [NUM_CH];
  logic [NUM_CH-1:0] vld    [NUM_TRIG];
  logic [CH_W:0]     pick   [NUM_TRIG];
  logic [NUM_CH-1:0] err_ev;

  // Scan from farthest to nearest so the last hit is the channel right after ptr.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] v,
                                            input logic [CH_W-1:0] ptr);
    logic [CH_W:0] res;
    int idx;
    res = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NUM_CH;
      if (v[idx]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    err_ev = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]    = bus.ch_trigout_sel[i*SEL_W +: SEL_W];
      err_ev[i] = bus.ch_trigout_req[i] && (sel[i] >= TRIG_LIM);
    end
    for (int k = 0; k < NUM_TRIG; k++) begin
      vld[k] = '0;
      for (int i = 0; i < NUM_CH; i++)
        vld[k][i] = bus.ch_trigout_req[i] && (sel[i] == SEL_W'(k));
      pick[k] = rr_pick(vld[k], p_q[k]);
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    p_d        = p_q;
    trig_req_d = trig_req_q;
    ch_ack_d   = '0;
    // A new error event in the same cycle as err_clr keeps the bit set.
    selerr_d   = err_ev | (selerr_q & ~{NUM_CH{bus.err_clr}});
    for (int k = 0; k < NUM_TRIG; k++) begin
      case (state_q[k])
        S_IDLE: begin
          if (pick[k][CH_W]) begin
            g_d[k]        = pick[k][CH_W-1:0];
            trig_req_d[k] = 1'b1;
            state_d[k]    = S_REQ;
          end
        end
        S_REQ: begin
          if (bus.trig_out_ack[k]) begin
            trig_req_d[k]    = 1'b0;
            ch_ack_d[g_q[k]] = 1'b1;
            p_d[k]           = g_q[k];
            state_d[k]       = S_ACK_LOW;
          end
        end
        S_ACK_LOW: begin
          if (!bus.trig_out_ack[k]) state_d[k] = S_IDLE;
        end
        default: state_d[k] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TRIG; k++) begin
        state_q[k] <= S_IDLE;
        g_q[k]     <= '0;
        p_q[k]     <= CH_W'(NUM_CH - 1);
      end
      trig_req_q <= '0;
      ch_ack_q   <= '0;
      selerr_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_TRIG; k++) state_q[k] <= state_d[k];
      g_q        <= g_d;
      p_q        <= p_d;
      trig_req_q <= trig_req_d;
      ch_ack_q   <= ch_ack_d;
      selerr_q   <= selerr_d;
    end
  end

  assign bus.trig_out_req   = trig_req_q;
  assign bus.ch_trigout_ack = ch_ack_q;
  assign bus.trigout_selerr = selerr_q;
endmodule

// File: tb/tb_trigout_arbiter.sv
// Scoreboard bench for trigout_arbiter: expected channel acks are queued by the stimulus
// and popped by an independent monitor whenever the DUT pulses ch_trigout_ack.
module tb_trigout_arbiter;
  localparam int NUM_CH   = 4;
  localparam int NUM_TRIG = 2;
  localparam int SEL_W    = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [NUM_CH-1:0] exp_q [$];

  always #5 clk = ~clk;

  trigout_arbiter_if #(.NUM_CH(NUM_CH), .NUM_TRIG(NUM_TRIG), .SEL_W(SEL_W)) bus ();

  trigout_arbiter #(.NUM_CH(NUM_CH), .NUM_TRIG(NUM_TRIG), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Monitor: every ack pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] e;
    if (bus.ch_trigout_ack !== '0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got %b, expected no ack", bus.ch_trigout_ack);
      end else begin
        e = exp_q.pop_front();
        if (bus.ch_trigout_ack !== e) begin
          n_fail++;
          $display("FAIL ch_ack_order: got %b, expected %b", bus.ch_trigout_ack, e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sel(input int ch, input logic [SEL_W-1:0] v);
    bus.ch_trigout_sel[ch*SEL_W +: SEL_W] = v;
  endtask

  // Peripheral: wait for req, ack after dly cycles, drop ack once req falls.
  task automatic periph(input int k, input int dly);
    int n;
    n = 0;
    while (bus.trig_out_req[k] !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL periph_req_rise line %0d: got timeout, expected trig_out_req", k);
    end
    repeat (dly) tick();
    bus.trig_out_ack[k] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.trig_out_req[k] !== 1'b0 && n < 20);
    if (n >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL periph_req_fall line %0d: got timeout, expected req drop", k);
    end
    bus.trig_out_ack[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ch_trigout_req = '0;
    bus.ch_trigout_sel = '0;
    bus.trig_out_ack   = '0;
    bus.err_clr        = 1'b0;
    repeat (3) tick();
    check("rst_trig_out_req", 32'(bus.trig_out_req), 0);
    check("rst_ch_ack", 32'(bus.ch_trigout_ack), 0);
    check("rst_selerr", 32'(bus.trigout_selerr), 0);
    rst = 1'b0;
    tick();

    // Single request on line 0
    set_sel(0, 0);
    bus.ch_trigout_req = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    check("t1_req_rise", 32'(bus.trig_out_req), 32'b01);
    tick();
    check("t1_req_hold1", 32'(bus.trig_out_req), 32'b01);
    tick();
    check("t1_req_hold2", 32'(bus.trig_out_req), 32'b01);
    bus.trig_out_ack[0] = 1'b1;
    tick();
    check("t1_req_fall", 32'(bus.trig_out_req), 0);
    bus.ch_trigout_req = '0;
    tick();
    check("t1_req_low", 32'(bus.trig_out_req), 0);
    bus.trig_out_ack[0] = 1'b0;
    repeat (3) tick();

    // Round-robin on line 1: ch0, ch1, ch3, then re-requested ch0
    set_sel(0, 1); set_sel(1, 1); set_sel(3, 1);
    bus.ch_trigout_req = 4'b1011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    periph(1, 1);
    bus.ch_trigout_req[0] = 1'b0;
    periph(1, 1);
    bus.ch_trigout_req[1] = 1'b0;
    bus.ch_trigout_req[0] = 1'b1;
    periph(1, 1);
    bus.ch_trigout_req[3] = 1'b0;
    periph(1, 1);
    bus.ch_trigout_req[0] = 1'b0;
    repeat (3) tick();
    check("t2_rr_drained", exp_q.size(), 0);

    // Concurrent lines: ch2 on line 0, ch1 on line 1
    set_sel(2, 0); set_sel(1, 1);
    bus.ch_trigout_req = 4'b0110;
    exp_q.push_back(4'b0110);
    tick();
    check("t3_both_req", 32'(bus.trig_out_req), 32'b11);
    bus.trig_out_ack = 2'b11;
    tick();
    check("t3_both_fall", 32'(bus.trig_out_req), 0);
    bus.ch_trigout_req = '0;
    bus.trig_out_ack   = 2'b00;
    repeat (3) tick();

    // Select error on ch3 with sel=5
    set_sel(3, 5);
    bus.ch_trigout_req = 4'b1000;
    tick();
    check("t4_selerr_set", 32'(bus.trigout_selerr), 32'b1000);
    check("t4_no_req", 32'(bus.trig_out_req), 0);
    tick();
    check("t4_no_req2", 32'(bus.trig_out_req), 0);
    bus.ch_trigout_req = '0;
    tick();
    check("t4_selerr_sticky", 32'(bus.trigout_selerr), 32'b1000);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t4_selerr_clr", 32'(bus.trigout_selerr), 0);
    bus.ch_trigout_req = 4'b1000;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    bus.ch_trigout_req = '0;
    check("t4_set_wins", 32'(bus.trigout_selerr), 32'b1000);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t4_selerr_clr2", 32'(bus.trigout_selerr), 0);
    tick();

    // Abort attempt: ch0 drops req while line 0 is in REQ
    set_sel(0, 0);
    bus.ch_trigout_req = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    check("t5_req_rise", 32'(bus.trig_out_req), 32'b01);
    bus.ch_trigout_req = '0;
    set_sel(0, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_req_held", 32'(bus.trig_out_req), 32'b01);
    end
    bus.trig_out_ack[0] = 1'b1;
    tick();
    check("t5_req_fall", 32'(bus.trig_out_req), 0);
    bus.trig_out_ack[0] = 1'b0;
    repeat (3) tick();

    // Reset mid-handshake, then pointer back at NUM_CH-1
    set_sel(0, 0); set_sel(3, 5);
    bus.ch_trigout_req = 4'b1001;
    tick();
    check("t6_pre_req", 32'(bus.trig_out_req), 32'b01);
    check("t6_pre_selerr", 32'(bus.trigout_selerr), 32'b1000);
    rst = 1'b1;
    bus.ch_trigout_req = '0;
    tick();
    check("t6_rst_req", 32'(bus.trig_out_req), 0);
    check("t6_rst_ack", 32'(bus.ch_trigout_ack), 0);
    check("t6_rst_selerr", 32'(bus.trigout_selerr), 0);
    rst = 1'b0;
    set_sel(1, 0);
    bus.ch_trigout_req = 4'b0011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    periph(0, 0);
    bus.ch_trigout_req[0] = 1'b0;
    periph(0, 0);
    bus.ch_trigout_req[1] = 1'b0;
    repeat (4) tick();

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trigout_arbiter.md
Name: trigout_arbiter

Overview:
Shares the peripheral trigger-output lines between all DMA channels.
Each channel raises a trigger-out request with a target trigger-output index. Per output line, the block arbitrates round-robin among the requesting channels and runs the 4-phase req/ack handshake with the peripheral. It returns a one-cycle acknowledge to the winning channel. The block sits between the per-channel trigger-out request logic and the external trig*_out_req/trig*_out_ack pins. Invalid selections are flagged.

Parameters:
NUM_CH, 4, number of DMA channels (2..8)
NUM_TRIG, 2, number of peripheral trigger-output lines (1..8)
SEL_W, 6, width of each channel's trigger-out select field

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ch_trigout_req  input  NUM_CH  per-channel trigger-out request (level; held until ack)
ch_trigout_sel  input  NUM_CH*SEL_W  per-channel target output index; channel i occupies bits [i*SEL_W +: SEL_W]
ch_trigout_ack  output  NUM_CH  one-cycle acknowledge to the granted channel
trig_out_req  output  NUM_TRIG  4-phase request to the peripheral
trig_out_ack  input  NUM_TRIG  4-phase acknowledge from the peripheral
trigout_selerr  output  NUM_CH  sticky select error per channel
err_clr  input  1  one-cycle pulse; clears all trigout_selerr bits

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge.
  - All outputs go to 0; all output FSMs go to IDLE.
  - Every round-robin pointer goes to NUM_CH-1, so channel 0 has first priority.
  - Reset mid-handshake drops trig_out_req immediately. There is no wait for the peripheral ack.
- Valid request for output k: ch_trigout_req[i]=1, sel_i==k, and sel_i<NUM_TRIG.
- Select error:
  - If ch_trigout_req[i]=1 and sel_i>=NUM_TRIG, trigout_selerr[i] is set next cycle and stays set until err_clr or rst.
  - A request with an invalid select is never granted and never acknowledged.
  - If err_clr and a new error event occur in the same cycle, set wins.
- Each output k has an independent FSM with states IDLE, REQ and ACK_LOW, plus registered grant index g_k and pointer p_k.
- IDLE:
  - If any valid request for k exists, pick the first requesting channel in the order p_k+1, p_k+2, ... modulo NUM_CH.
  - Register it in g_k, set trig_out_req[k]<=1 and go to REQ.
  - Latency: a request sampled at edge t gives trig_out_req[k]=1 after edge t.
  - With no valid request, stay in IDLE.
- REQ:
  - trig_out_req[k] is held at 1. The request cannot be aborted: if the channel drops its request or changes sel, the handshake still completes and the ack is still pulsed to g_k.
  - When trig_out_ack[k]=1 is sampled: trig_out_req[k]<=0, ch_trigout_ack[g_k]<=1 for exactly one cycle, p_k<=g_k, go to ACK_LOW.
- ACK_LOW:
  - Wait until trig_out_ack[k]=0 is sampled, then go to IDLE.
  - Requests arriving in ACK_LOW are held off until IDLE.
  - The minimum period between successive grants on one line is 3 cycles.
- Channel obligation: the channel deasserts ch_trigout_req the cycle after it sees ch_trigout_ack. Because the pointer has advanced, a request held longer is treated as a new request behind the other requesters.
- Outputs are independent. Different channels targeting different lines are serviced concurrently.
- One channel can target only one line at a time, so ch_trigout_ack bits from different FSMs never collide on the same channel.
- An ack already high when the FSM enters REQ completes the handshake on the first REQ cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Single request: ch0 req, sel=0; ack0 rises 2 cycles after trig_out_req[0] -> trig_out_req[0] goes high 1 cycle after req and falls the cycle after ack is sampled; ch_trigout_ack=4'b0001 for exactly 1 cycle; FSM returns to IDLE after ack0 falls.
2. Round-robin: ch0, ch1 and ch3 all req with sel=1, held; peripheral acks each after 1 cycle -> grant order ch0, ch1, ch3, then ch0 again if re-requested; no channel granted twice while another waits.
3. Concurrency: ch2 sel=0 and ch1 sel=1 in the same cycle -> trig_out_req=2'b11 in the same cycle; each ack routed only to its owner (ch2 on line 0, ch1 on line 1).
4. Select error: ch3 req with sel=5 (NUM_TRIG=2) -> trigout_selerr[3]=1 next cycle; trig_out_req stays 0; selerr persists after req drops; err_clr pulse clears it; err_clr coincident with a new error leaves it set.
5. Abort attempt: ch0 drops req while in REQ -> trig_out_req[0] stays high until ack0; ch_trigout_ack[0] still pulses.
6. Reset mid-op: assert rst while in REQ with ack0 low -> next cycle all outputs 0, pointers at NUM_CH-1; after rst release, ch1 and ch0 requesting -> ch0 granted first.
